// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises and debounces an external active-low reset
// request, then releases the domain resets one at a time, bit 0 first, with
// a fixed gap between releases. Every domain reset asserts the moment RST
// rises and deasserts only on a CLK edge.

// One domain reset flop. Clear beats set, so a new request landing on the
// same edge as this domain's release keeps the domain in reset.
module reset_sequencer_domain (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic set,
  output logic rst_n
);

  // Asserts asynchronously; deasserts only on the release strobe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      rst_n <= 1'b0;
    else if (clr) rst_n <= 1'b0;
    else if (set) rst_n <= 1'b1;
  end

endmodule

module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int NUM_DOMAINS = 3,
  parameter int RELEASE_GAP = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SW_RST_n,
  output logic [NUM_DOMAINS-1:0] RST_n_OUT,
  output logic                   READY,
  output logic [7:0]             REQ_CNT
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int GW = $clog2(RELEASE_GAP + 1);
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] RELEASE = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_req;
  logic [FW-1:0]          flt_cnt;
  logic                   flt_req;
  logic [1:0]             state;
  logic [GW-1:0]          gap_cnt;
  logic [IW-1:0]          idx;
  logic                   slot_done;
  logic                   last_dom;
  logic                   rel_stb;
  logic                   dom_clr;

  // Synchroniser chain. It resets to 0, so a fresh RST reads as "requesting"
  // until the pin has been seen high through the whole chain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], SW_RST_n};
  end

  assign sync_req = ~sync_q[SYNC_STAGES-1];

  // Debounce: the filtered request flips only after FILTER_LEN consecutive
  // samples disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flt_cnt <= '0;
      flt_req <= 1'b1;
    end else if (sync_req != flt_req) begin
      if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        flt_req <= ~flt_req;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end else begin
      flt_cnt <= '0;
    end
  end

  assign slot_done = (gap_cnt == GW'(RELEASE_GAP - 1));
  assign last_dom  = (idx == IW'(NUM_DOMAINS - 1));
  assign rel_stb   = (state == RELEASE) && slot_done;
  // A request out of RELEASE/RUN drops every domain on the same edge the
  // state machine returns to HOLD.
  assign dom_clr   = (state == HOLD) || flt_req;

  // Sequencing FSM plus the READY flag and the saturating request counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= HOLD;
      gap_cnt <= '0;
      idx     <= '0;
      READY   <= 1'b0;
      REQ_CNT <= 8'd0;
    end else begin
      case (state)
        HOLD: begin
          READY <= 1'b0;
          if (!flt_req) begin
            state   <= RELEASE;
            idx     <= '0;
            gap_cnt <= '0;
          end
        end
        RELEASE: begin
          if (flt_req) begin
            state <= HOLD;
            READY <= 1'b0;
            if (REQ_CNT != 8'hFF) REQ_CNT <= REQ_CNT + 8'd1;
          end else if (slot_done) begin
            gap_cnt <= '0;
            if (last_dom) begin
              state <= RUN;
              READY <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        RUN: begin
          if (flt_req) begin
            state <= HOLD;
            READY <= 1'b0;
            if (REQ_CNT != 8'hFF) REQ_CNT <= REQ_CNT + 8'd1;
          end
        end
        default: begin
          state <= HOLD;
          READY <= 1'b0;
        end
      endcase
    end
  end

  // Per-domain reset flops. Only the domain selected by idx sees the strobe,
  // so bits can only come out of reset in ascending order.
  for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_dom
    reset_sequencer_domain u_dom (
      .CLK   (CLK),
      .RST   (RST),
      .clr   (dom_clr),
      .set   (rel_stb && (idx == IW'(k))),
      .rst_n (RST_n_OUT[k])
    );
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: stimulus pushes the expected output changes,
// each tagged with the edge it should appear on, and per-DUT monitors pop
// and compare every time the observed outputs change.
module tb_reset_sequencer;

  typedef struct {
    int          cyc;
    logic [11:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst6 = 1'b1;
  logic       sw = 1'b1;
  logic       sw6 = 1'b1;
  logic [2:0] rst_n_out;
  logic       ready;
  logic [7:0] req_cnt;
  logic [0:0] rst_n6;
  logic       ready6;
  logic [7:0] req_cnt6;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  exp_t        q[$];
  exp_t        q6[$];
  logic [11:0] prev = '0;
  logic [11:0] prev6 = '0;

  reset_sequencer dut (
    .CLK(clk), .RST(rst), .SW_RST_n(sw),
    .RST_n_OUT(rst_n_out), .READY(ready), .REQ_CNT(req_cnt)
  );

  reset_sequencer #(.SYNC_STAGES(2), .FILTER_LEN(1), .NUM_DOMAINS(1), .RELEASE_GAP(1)) dut6 (
    .CLK(clk), .RST(rst6), .SW_RST_n(sw6),
    .RST_n_OUT(rst_n6), .READY(ready6), .REQ_CNT(req_cnt6)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int c, input logic [2:0] r, input logic rd, input int n);
    exp_t e;
    e.cyc = c;
    e.val = {r, rd, 8'(n)};
    return e;
  endfunction

  function automatic exp_t mk6(input int c, input logic r, input logic rd, input int n);
    exp_t e;
    e.cyc = c;
    e.val = {2'b00, r, rd, 8'(n)};
    return e;
  endfunction

  // Main DUT monitor: every output change must match the next expected one.
  always @(negedge clk) begin : mon_main
    logic [11:0] cur;
    exp_t        e;
    cur = {rst_n_out, ready, req_cnt};
    if (mon_en && cur !== prev) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL main.unexpected: got 0x%0h expected no change from 0x%0h (cycle %0d)", cur, prev, cyc);
      end else begin
        e = q.pop_front();
        chk("main.cycle", cyc, e.cyc);
        chk("main.value", cur, e.val);
      end
      prev = cur;
    end
  end

  // Small-parameter DUT monitor.
  always @(negedge clk) begin : mon_six
    logic [11:0] cur;
    exp_t        e;
    cur = {2'b00, rst_n6, ready6, req_cnt6};
    if (mon_en && cur !== prev6) begin
      if (q6.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL p6.unexpected: got 0x%0h expected no change from 0x%0h (cycle %0d)", cur, prev6, cyc);
      end else begin
        e = q6.pop_front();
        chk("p6.cycle", cyc, e.cyc);
        chk("p6.value", cur, e.val);
      end
      prev6 = cur;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || q6.size() != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0 || q6.size() != 0) begin
      failures++;
      $display("FAIL %s.drain: got %0d/%0d pending changes expected 0/0 after %0d cycles",
               name, q.size(), q6.size(), budget);
      q.delete();
      q6.delete();
    end
  endtask

  // Release sequence of the default DUT, counted from base (pin high before edge base+1).
  task automatic push_release(input int base, input int n);
    q.push_back(mk(base + 15, 3'b001, 1'b0, n));
    q.push_back(mk(base + 23, 3'b011, 1'b0, n));
    q.push_back(mk(base + 31, 3'b111, 1'b1, n));
  endtask

  initial begin
    int b;
    int b2;
    int b4;

    // Power-up
    rst = 1'b1; rst6 = 1'b1; sw = 1'b1;
    wait_cyc(3);
    chk("reset.rst_n", rst_n_out, 0);
    chk("reset.ready", ready, 0);
    chk("reset.req_cnt", req_cnt, 0);
    chk("reset.p6_rst_n", rst_n6, 0);
    mon_en = 1'b1;
    b = cyc;
    push_release(b, 0);
    q6.push_back(mk6(b + 5, 1'b1, 1'b1, 0));
    rst = 1'b0; rst6 = 1'b0;
    drain("powerup", 60);

    // Two-cycle glitch in RUN must not propagate
    sw = 1'b0;
    wait_cyc(2);
    sw = 1'b1;
    wait_cyc(12);
    chk("glitch.rst_n", rst_n_out, 3'b111);
    chk("glitch.req_cnt", req_cnt, 0);

    // Ten-cycle request in RUN, then full re-release
    b = cyc;
    q.push_back(mk(b + 7, 3'b000, 1'b0, 1));
    push_release(b + 10, 1);
    sw = 1'b0;
    wait_cyc(10);
    sw = 1'b1;
    drain("request", 60);

    // Abort while only domain 0 is released; restart must begin at bit 0
    b = cyc;
    b2 = b + 10;
    b4 = b2 + 25;
    q.push_back(mk(b + 7, 3'b000, 1'b0, 2));
    q.push_back(mk(b2 + 15, 3'b001, 1'b0, 2));
    q.push_back(mk(b2 + 22, 3'b000, 1'b0, 3));
    push_release(b4, 3);
    sw = 1'b0;
    wait_cyc(10);
    sw = 1'b1;
    wait_cyc(15);
    sw = 1'b0;
    wait_cyc(10);
    sw = 1'b1;
    drain("abort", 90);

    // 3 ns RST pulse between edges in RUN
    b = cyc;
    q.push_back(mk(b + 1, 3'b000, 1'b0, 0));
    push_release(b, 0);
    rst = 1'b1;
    #2;
    chk("async.mid_rst_n", rst_n_out, 0);
    chk("async.mid_ready", ready, 0);
    #1;
    rst = 1'b0;
    chk("async.rst_n", rst_n_out, 0);
    chk("async.ready", ready, 0);
    chk("async.req_cnt", req_cnt, 0);
    drain("async", 60);

    // 260 requests, each aborting the release before domain 0 comes up
    b = cyc;
    for (int i = 0; i < 260; i++) begin
      if (i == 0)        q.push_back(mk(b + 7, 3'b000, 1'b0, 1));
      else if (i < 255)  q.push_back(mk(b + 14 * i + 7, 3'b000, 1'b0, i + 1));
    end
    push_release(b + 14 * 259 + 8, 255);
    for (int i = 0; i < 260; i++) begin
      sw = 1'b0;
      wait_cyc(8);
      sw = 1'b1;
      wait_cyc(6);
    end
    drain("saturate", 60);
    chk("saturate.req_cnt", req_cnt, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
